// File: rtl/div_seq_ctrl_if.sv
// Handshake and datapath-control bundle between the divider controller,
// the top-level start/valid/ack logic and the remainder/quotient datapath.
interface div_seq_ctrl_if;
  logic       start;
  logic       mode;
  logic       sign;
  logic       ack;
  logic       load;
  logic [1:0] sel;
  logic       add;
  logic       shift;
  logic       inbit;
  logic       busy;
  logic       valid;

  modport master (
    input  start, mode, sign, ack,
    output load, sel, add, shift, inbit, busy, valid
  );

  modport slave (
    output start, mode, sign, ack,
    input  load, sel, add, shift, inbit, busy, valid
  );
endinterface

// File: rtl/div_seq_ctrl.sv
// Sequencer for the iterative divider: restoring (trial/adjust per bit) or
// non-restoring (one step per bit plus a final remainder correction).
module div_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic           clk,
  input  logic           reset,
  div_seq_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, LOAD, TRIAL, RESTORE, ACCEPT, NR_STEP, CORRECT, DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             load_q, add_q, shift_q, inbit_q, busy_q, valid_q;
  logic [1:0]       sel_q;
  logic             last_iter;

  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  // start wins from every state, so a running operation is dropped silently.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    if (bus.start) begin
      state_d = LOAD;
      cnt_d   = '0;
      mode_d  = bus.mode;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        LOAD:    state_d = mode_q ? NR_STEP : TRIAL;
        TRIAL:   state_d = bus.sign ? RESTORE : ACCEPT;
        RESTORE,
        ACCEPT: begin
          if (last_iter) begin
            state_d = DONE;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = TRIAL;
          end
        end
        NR_STEP: begin
          if (last_iter) begin
            state_d = CORRECT;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = NR_STEP;
          end
        end
        CORRECT: state_d = DONE;
        DONE:    state_d = bus.ack ? IDLE : DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Moore outputs are decoded from the next state so they appear registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      load_q  <= 1'b0;
      sel_q   <= 2'd0;
      add_q   <= 1'b0;
      shift_q <= 1'b0;
      inbit_q <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      load_q  <= 1'b0;
      sel_q   <= 2'd0;
      add_q   <= 1'b0;
      shift_q <= 1'b0;
      inbit_q <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      case (state_d)
        LOAD: begin
          load_q  <= 1'b1;
          sel_q   <= 2'd2;
          shift_q <= 1'b1;
          busy_q  <= 1'b1;
        end
        TRIAL: begin
          sel_q  <= 2'd1;
          busy_q <= 1'b1;
        end
        RESTORE: begin
          sel_q   <= 2'd1;
          add_q   <= 1'b1;
          shift_q <= 1'b1;
          busy_q  <= 1'b1;
        end
        ACCEPT: begin
          sel_q   <= 2'd3;
          shift_q <= 1'b1;
          inbit_q <= 1'b1;
          busy_q  <= 1'b1;
        end
        NR_STEP: begin
          sel_q   <= 2'd1;
          shift_q <= 1'b1;
          busy_q  <= 1'b1;
        end
        CORRECT: begin
          add_q  <= 1'b1;
          busy_q <= 1'b1;
        end
        DONE:    valid_q <= 1'b1;
        default: ;
      endcase
    end
  end

  // Non-restoring step and final correction must react to sign in-cycle.
  assign bus.load  = load_q;
  assign bus.sel   = (state_q == CORRECT) ? {1'b0, bus.sign} : sel_q;
  assign bus.add   = add_q | ((state_q == NR_STEP) & bus.sign);
  assign bus.inbit = inbit_q | ((state_q == NR_STEP) & ~bus.sign);
  assign bus.shift = shift_q;
  assign bus.busy  = busy_q;
  assign bus.valid = valid_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed bench for div_seq_ctrl: a vector table for a non-restoring run plus
// hand-written restoring, reset, restart and WIDTH=16 sequences.
module tb_div_seq_ctrl;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  div_seq_ctrl_if bus8 ();
  div_seq_ctrl_if bus16 ();

  div_seq_ctrl #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8.master)
  );

  div_seq_ctrl #(.WIDTH(16)) dut16 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus16.master)
  );

  // Output bundle order: {load, sel[1:0], add, shift, inbit, busy, valid}
  localparam logic [7:0] IDLE_O  = 8'b0_00_0_0_0_0_0;
  localparam logic [7:0] LOAD_O  = 8'b1_10_0_1_0_1_0;
  localparam logic [7:0] TRIAL_O = 8'b0_01_0_0_0_1_0;
  localparam logic [7:0] REST_O  = 8'b0_01_1_1_0_1_0;
  localparam logic [7:0] ACC_O   = 8'b0_11_0_1_1_1_0;
  localparam logic [7:0] NR0_O   = 8'b0_01_0_1_1_1_0;
  localparam logic [7:0] NR1_O   = 8'b0_01_1_1_0_1_0;
  localparam logic [7:0] CORR0_O = 8'b0_00_1_0_0_1_0;
  localparam logic [7:0] CORR1_O = 8'b0_01_1_0_0_1_0;
  localparam logic [7:0] DONE_O  = 8'b0_00_0_0_0_0_1;

  typedef struct {
    logic       start;
    logic       mode;
    logic       sign;
    logic       ack;
    logic [7:0] expOut;
  } vec_t;

  vec_t vecs[15];
  int   checkCount = 0;
  int   passCount  = 0;
  bit   useWide    = 1'b0;

  function automatic logic [7:0] packOut(input bit wide);
    if (wide)
      return {bus16.load, bus16.sel, bus16.add, bus16.shift, bus16.inbit, bus16.busy, bus16.valid};
    return {bus8.load, bus8.sel, bus8.add, bus8.shift, bus8.inbit, bus8.busy, bus8.valid};
  endfunction

  task automatic applyStimulus(input logic s, input logic m, input logic sg, input logic a);
    @(negedge clk);
    if (useWide) begin
      bus16.start = s; bus16.mode = m; bus16.sign = sg; bus16.ack = a;
      bus8.start  = 1'b0; bus8.ack = 1'b0;
    end else begin
      bus8.start  = s; bus8.mode = m; bus8.sign = sg; bus8.ack = a;
      bus16.start = 1'b0; bus16.ack = 1'b0;
    end
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] expOut);
    logic [7:0] act;
    act = packOut(useWide);
    checkCount++;
    if (act === expOut) passCount++;
    else $display("[TB] FAIL %s: got %b want %b (load,sel,add,shift,inbit,busy,valid)",
                  name, act, expOut);
  endtask

  task automatic checkValue(input string name, input int act, input int expVal);
    checkCount++;
    if (act == expVal) passCount++;
    else $display("[TB] FAIL %s: got %0d want %0d", name, act, expVal);
  endtask

  // Runs idle inputs until valid shows; returns edges seen, capped at 60.
  task automatic countToValid(output int edges);
    logic [7:0] o;
    edges = 0;
    while (edges < 60) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      edges++;
      o = packOut(useWide);
      if (o[0]) break;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int         edges;
    int         loadCycles;
    int         validSeen;
    logic [7:0] inbits;
    logic       sg;
    logic [7:0] o;

    bus8.start = 1'b0;  bus8.mode = 1'b0;  bus8.sign = 1'b0;  bus8.ack = 1'b0;
    bus16.start = 1'b0; bus16.mode = 1'b0; bus16.sign = 1'b0; bus16.ack = 1'b0;
    reset = 1'b0;
    #2 reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset8", IDLE_O);
    useWide = 1'b1;
    checkOutput("reset16", IDLE_O);
    useWide = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // Non-restoring WIDTH=8, sign=0 throughout, then ack; ack again in IDLE.
    vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, IDLE_O};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, LOAD_O};
    for (int i = 2; i < 10; i++) vecs[i] = '{1'b0, 1'b0, 1'b0, 1'b0, NR0_O};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, CORR0_O};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, DONE_O};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, DONE_O};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, IDLE_O};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b0, IDLE_O};
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].start, vecs[i].mode, vecs[i].sign, vecs[i].ack);
      checkOutput($sformatf("vec[%0d]", i), vecs[i].expOut);
    end

    // Restoring, sign alternating 1,0 on each TRIAL.
    loadCycles = 0;
    inbits = '0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    edges = 1;
    loadCycles += int'(bus8.load);
    checkOutput("rs_load", LOAD_O);
    for (int i = 0; i < 8; i++) begin
      sg = ((i % 2) == 0);
      applyStimulus(1'b0, 1'b0, sg, 1'b0);
      edges++;
      loadCycles += int'(bus8.load);
      checkOutput($sformatf("rs_trial%0d", i), TRIAL_O);
      applyStimulus(1'b0, 1'b0, ~sg, 1'b0);
      edges++;
      loadCycles += int'(bus8.load);
      inbits[7-i] = bus8.inbit;
      checkOutput($sformatf("rs_adjust%0d", i), sg ? REST_O : ACC_O);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    edges++;
    checkOutput("rs_done", DONE_O);
    checkValue("rs_validEdge", edges, 18);
    checkValue("rs_loadCycles", loadCycles, 1);
    checkValue("rs_inbits", int'(inbits), int'(8'b0101_0101));
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput($sformatf("rs_hold%0d", i), DONE_O);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("rs_ackCycle", DONE_O);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rs_idle", IDLE_O);

    // Asynchronous reset while in TRIAL.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_trial", TRIAL_O);
    #1 reset = 1'b1;
    #1;
    checkOutput("rst_async", IDLE_O);
    @(negedge clk);
    reset = 1'b0;
    validSeen = 0;
    for (int i = 0; i < 25; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      validSeen += int'(bus8.valid) + int'(bus8.busy);
    end
    checkValue("rst_quiet", validSeen, 0);

    // Restart in cycle 5 of a restoring operation, same mode.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rr_load", LOAD_O);
    countToValid(edges);
    checkValue("rr_validEdge", edges + 1, 18);

    // Restart with a mode change: restoring run replaced by non-restoring.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rm_load", LOAD_O);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rm_nrStep", NR0_O);
    countToValid(edges);
    checkValue("rm_validEdge", edges + 2, 11);

    // start and ack together in DONE: start wins.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("sa_done", DONE_O);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("sa_load", LOAD_O);
    countToValid(edges);
    checkValue("sa_validEdge", edges + 1, 18);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("sa_idle", IDLE_O);

    // WIDTH=16 non-restoring, sign=1 only on the final step and in CORRECT.
    useWide = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    edges = 1;
    checkOutput("w16_load", LOAD_O);
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      edges++;
      checkOutput($sformatf("w16_nr%0d", i), NR0_O);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    edges++;
    checkOutput("w16_nrLast", NR1_O);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    edges++;
    checkOutput("w16_correct", CORR1_O);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    edges++;
    o = packOut(1'b1);
    checkOutput("w16_done", DONE_O);
    checkValue("w16_validEdge", o[0] ? edges : 0, 19);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("w16_idle", IDLE_O);
    useWide = 1'b0;

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
